mips_cpu_bus_ctrl: RTL
======================

// Module: mips_cpu_bus_ctrl
// PURPOSE
//   Bus master adapter between the MIPS core's load/store/fetch request port and the Avalon-style memory bus.
//   Turns one core request (byte/half/word, signed/unsigned) into a single aligned word bus cycle.
//   Honours waitrequest, generates byteenable and lane-replicated writedata, and extracts/extends read data.
//   Lane convention: bus byte at addr+k is readdata/writedata[31-8k -: 8], enabled by byteenable[k].
// PARAMETERS
//   TIMEOUT_CYCLES  256  waitrequest stall limit before abort (used only when BUS_CTRL_TIMEOUT_EN is defined)
// PORTS
//   clk          in   1   system clock; all state changes on rising edge
//   reset        in   1   synchronous, active-high reset
//   req_valid    in   1   core request present
//   req_write    in   1   1=store, 0=load/fetch
//   req_size     in   2   00=byte, 01=half, 10=word (11 treated as word)
//   req_signed   in   1   sign-extend load result (byte/half only)
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data, right-justified
//   req_ready    out  1   request accepted this cycle (high only in IDLE)
//   resp_valid   out  1   one-cycle pulse: transaction complete
//   resp_rdata   out  32  extended load data, valid with resp_valid (0 for stores)
//   resp_err     out  1   with resp_valid: misaligned request or timeout
//   address      out  32  bus address, always {req_addr[31:2],2'b00}
//   read         out  1   bus read strobe
//   write        out  1   bus write strobe
//   byteenable   out  4   byte lane enables
//   writedata    out  32  bus write data
//   waitrequest  in   1   slave stall; strobes/address/data held while high
//   readdata     in   32  bus read data, valid the cycle after read && !waitrequest
// BEHAVIOUR
//   Reset: state=IDLE; read=write=0; address=0; byteenable=0; writedata=0; resp_valid=0; resp_rdata=0; resp_err=0.
//   States: IDLE -> BUS -> (RDATA) -> RESP -> IDLE.
//   IDLE: req_ready=1. On req_valid, latch request (address, write, size, signed, offset=req_addr[1:0], data).
//     Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP with resp_err=1; no bus strobe is ever issued.
//     Else -> BUS with read or write asserted from the next cycle.
//   BUS: hold address/byteenable/writedata/strobe stable. Edge with waitrequest=0 accepts the cycle:
//     strobe drops next cycle; write -> RESP; read -> RDATA.
//   RDATA: sample readdata on this edge; extract and extend; -> RESP.
//   RESP: resp_valid=1 for exactly one cycle; -> IDLE. New request accepted no earlier than the following cycle.
//   Latency with zero wait: store 3 cycles req->resp_valid; load 4 cycles. Each waitrequest cycle adds 1.
//   Byteenable/writedata: byte k: be=1<<k, wd={4{wdata[7:0]}}; half off0: be=0011, off2: be=1100,
//     wd={2{wdata[15:0]}}; word: be=1111, wd=wdata. Reads drive be=1111.
//   Load extract: byte k = readdata[31-8k -: 8]; half off0 = [31:16], off2 = [15:0];
//     req_signed=1 sign-extends, else zero-extends; word is passed through and req_signed is ignored.
//   read and write are never high together. Strobes are never asserted outside BUS.
//   reset high in any state aborts immediately: strobes drop on that edge, no resp_valid is issued.
//   req_valid while not in IDLE is ignored (req_ready=0); the core must hold the request.
// CONFIGURATION
//   BUS_CTRL_TIMEOUT_EN defined: counter increments each BUS cycle with waitrequest=1.
//     Reaching TIMEOUT_CYCLES drops the strobe -> RESP with resp_err=1, resp_rdata=0. Counter clears on BUS entry.
//   Not defined: no counter; BUS waits indefinitely; resp_err only flags misalignment.
// TESTING
//   1 lw 0x10, waitrequest=0, mem bytes 0x10..0x13=DE AD BE EF -> one read strobe, be=1111,
//     resp_rdata=0xDEADBEEF 4 cycles after accept.
//   2 lb signed 0x13 (byte 0x80) -> address=0x10, resp_rdata=0xFFFFFF80; lbu -> 0x00000080.
//   3 sh 0x12 wdata=0x0000ABCD with waitrequest high 3 cycles -> address/be=1100/wd=ABCDABCD held 3 cycles,
//     write strobe exactly 4 cycles, bytes 0x12,0x13=AB,CD.
//   4 lw 0x06 -> resp_valid with resp_err=1, read/write stay 0 throughout.
//   5 reset asserted during BUS of a load -> next cycle read=0, no resp_valid, req_ready=1.
//   6 (BUS_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=4) waitrequest stuck high -> resp_err=1 after 4 stall cycles, strobe dropped.

Source files
------------

// File: rtl/mips_cpu_bus_ctrl.sv
// mips_cpu_bus_ctrl: adapts one core load/store/fetch request into one aligned Avalon word cycle
module mips_cpu_bus_ctrl #(parameter int TIMEOUT_CYCLES = 256) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);
  typedef enum logic [1:0] {IDLE, BUS, RDATA, RESP} state_t;
  state_t state, next;
  logic        write_q, signed_q, err_q, mis, tmo, accept;
  logic [1:0]  size_q, off_q;
  logic [3:0]  be_c;
  logic [31:0] wd_c, rsh, ext;
  logic [7:0]  b;
  logic [15:0] h;
  assign accept = state == IDLE && req_valid;
  assign req_ready = state == IDLE;
  assign mis = req_size == 2'b00 ? 1'b0 : req_size == 2'b01 ? req_addr[0] : |req_addr[1:0];
  assign be_c = !req_write ? 4'b1111 : req_size[1] ? 4'b1111 :
                req_size[0] ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << req_addr[1:0];
  assign wd_c = req_size[1] ? req_wdata : req_size[0] ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
  assign rsh = readdata << {off_q, 3'b000};
  assign b = rsh[31:24];
  assign h = off_q[1] ? readdata[15:0] : readdata[31:16];
  assign ext = size_q[1] ? readdata : size_q[0] ? {{16{signed_q & h[15]}}, h} : {{24{signed_q & b[7]}}, b};
`ifdef BUS_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign tmo = state == BUS && waitrequest && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset || accept) cnt <= '0;
    else if (state == BUS && waitrequest) cnt <= cnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (req_valid ? (mis ? RESP : BUS) : IDLE) :
           state == BUS ? (!waitrequest ? (write_q ? RESP : RDATA) : tmo ? RESP : BUS) :
           state == RDATA ? RESP : IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      byteenable <= '0;
      writedata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
    end else begin
      if (accept) begin
        address    <= {req_addr[31:2], 2'b00};
        read       <= !mis && !req_write;
        write      <= !mis && req_write;
        byteenable <= be_c;
        writedata  <= wd_c;
        write_q    <= req_write;
        signed_q   <= req_signed;
        size_q     <= req_size;
        off_q      <= req_addr[1:0];
        err_q      <= mis;
        resp_rdata <= '0;
      end
      if (state == BUS && (!waitrequest || tmo)) begin
        read  <= 1'b0;
        write <= 1'b0;
        err_q <= tmo;
      end
      if (state == RDATA) resp_rdata <= ext;
      resp_valid <= state == RESP;
      resp_err   <= state == RESP && err_q;
    end
  end
endmodule
